gshare_bht: RTL
===============

GSHARE_BHT -- requirements
Module: gshare_bht

Interface
REQ-001 Parameter SET_LEN, default 12, log2 of the pattern-table entry count (SET_SIZE = 2^SET_LEN).
REQ-002 Parameter BITS, default 2, saturating-counter width (MAX_VAL = 2^BITS-1, THRESHOLD = MAX_VAL/2, integer division).
REQ-003 Parameter GHR_LEN, default 8, global-history length; legal range 1..SET_LEN.
REQ-004 Parameter MODE, default 1; 0 = bimodal (PC-only index), 1 = gshare (PC XOR history index).
REQ-005 Parameter PC_LSB, default 2, lowest PC bit used for indexing.
REQ-006 Parameter INIT_VAL, default THRESHOLD, counter value written during initialisation.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 PC_query  input  32  PC of the branch being predicted.
REQ-010 PC_update  input  32  PC of the resolved branch.
REQ-011 GHR_update  input  GHR_LEN  history snapshot (from GHR_out) captured when the resolved branch was predicted.
REQ-012 BR  input  1  resolved outcome, 1 = taken; valid only while update = 1.
REQ-013 update  input  1  training strobe, one table update per asserted cycle.
REQ-014 BHT_br  output  1  combinational prediction, 1 = taken.
REQ-015 GHR_out  output  GHR_LEN  current global history register, for the pipeline to carry to GHR_update.
REQ-016 ready  output  1  1 when initialisation is complete and the block is accepting updates.

Function
REQ-017 Query index qi = PC_query[PC_LSB+SET_LEN-1:PC_LSB] when MODE=0, else that field XOR GHR zero-extended to SET_LEN bits.
REQ-018 Update index ui is formed identically from PC_update and GHR_update (never the live GHR).
REQ-019 Two-state FSM: INIT and RUN; a 1-cycle-per-entry sweep counter idx (SET_LEN bits) is active in INIT only.
REQ-020 INIT: each cycle write INIT_VAL to entry idx, idx increments; after writing entry SET_SIZE-1 the FSM enters RUN next cycle; INIT lasts exactly SET_SIZE cycles.
REQ-021 In INIT: ready = 0, BHT_br = 0, update strobes ignored (no table write, no GHR change).
REQ-022 In RUN: ready = 1, BHT_br = 1 iff entry[qi] > THRESHOLD.
REQ-023 RUN with update=1, BR=1: entry[ui] increments, saturating at MAX_VAL.
REQ-024 RUN with update=1, BR=0: entry[ui] decrements, saturating at 0.
REQ-025 RUN with update=1: GHR <= {GHR[GHR_LEN-2:0], BR} (for GHR_LEN=1, GHR <= BR), same edge as the table write.
REQ-026 Same-cycle query and update to the same index: BHT_br reflects the pre-update value; new value visible from the next cycle.
REQ-027 Counter arithmetic is BITS wide with no wrap-around; MAX_VAL+1 and 0-1 never occur.
REQ-028 Index XOR wraps naturally within SET_LEN bits; PC bits outside the index field have no effect.

Reset
REQ-029 On rst=1 at a clock edge: FSM <= INIT, idx <= 0, GHR <= 0; ready = 0 and BHT_br = 0 from the following cycle.
REQ-030 rst asserted mid-INIT or mid-RUN restarts the full SET_SIZE-cycle sweep; table contents are not cleared in the reset cycle itself.
REQ-031 rst has priority over update in the same cycle.

Verification
REQ-032 SET_LEN=4: rst pulse -> ready=0 for exactly 16 cycles, then 1; every entry reads 1 (INIT_VAL, BITS=2), BHT_br=0 for all PCs.
REQ-033 MODE=0, PC=0x10, 3 updates BR=1 -> counter 1->2->3->3, BHT_br=1 after the first; 3 updates BR=0 -> 2,1,0, BHT_br=0 after the second.
REQ-034 MODE=1, GHR_LEN=4: updates BR=1,0,1,1 -> GHR_out = 4'b1011; query PC_query=0x2C (field 0xB) -> qi = 0x0; verify entry 0 is read.
REQ-035 Same-cycle update BR=1 and query on index with counter 1 -> BHT_br=0 that cycle, 1 next cycle.
REQ-036 Updates during INIT and a rst issued at sweep entry 7 -> no table/GHR change, ready stays 0 for 16 further cycles.
REQ-037 Saturation: 10 consecutive BR=1 on one index with BITS=3 -> counter holds 7, no wrap to 0.

Source files
------------

// File: rtl/gshare_bht_if.sv
`default_nettype none
// ============================================================================
// Module   : gshare_bht_if
// Brief    : Query/update/status bundle between the pipeline and gshare_bht.
// Revision : 1.0 - initial release
// ============================================================================
interface gshare_bht_if #(
    parameter int GHR_LEN = 8
);
    logic [31:0]        PC_query;
    logic [31:0]        PC_update;
    logic [GHR_LEN-1:0] GHR_update;
    logic               BR;
    logic               update;
    logic               BHT_br;
    logic [GHR_LEN-1:0] GHR_out;
    logic               ready;

    modport master (
        output PC_query, PC_update, GHR_update, BR, update,
        input  BHT_br, GHR_out, ready
    );

    modport slave (
        input  PC_query, PC_update, GHR_update, BR, update,
        output BHT_br, GHR_out, ready
    );
endinterface
`default_nettype wire

// File: rtl/gshare_bht.sv
`default_nettype none
// ============================================================================
// Module   : gshare_bht
// Brief    : Bimodal/gshare branch predictor with saturating counters and a
//            one-entry-per-cycle initialisation sweep.
// Revision : 1.0 - initial release
// ============================================================================
module gshare_bht #(
    parameter int SET_LEN  = 12,
    parameter int BITS     = 2,
    parameter int GHR_LEN  = 8,
    parameter int MODE     = 1,
    parameter int PC_LSB   = 2,
    parameter int INIT_VAL = ((1 << BITS) - 1) / 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    gshare_bht_if.slave bus
);

    localparam int              c_set_size  = 1 << SET_LEN;
    localparam logic [BITS-1:0] c_max_val   = '1;
    localparam logic [BITS-1:0] c_threshold = c_max_val >> 1;
    localparam logic [BITS-1:0] c_init_val  = BITS'(INIT_VAL);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [SET_LEN-1:0]   idx_q;
    logic [GHR_LEN-1:0]   ghr_q;
    logic [GHR_LEN-1:0]   ghr_d;
    logic                 ready_q;
    logic [BITS-1:0]      table_q [c_set_size];

    logic [SET_LEN-1:0]   w_qi;
    logic [SET_LEN-1:0]   w_ui;
    logic [BITS-1:0]      w_upd_cur;
    logic [BITS-1:0]      w_upd_nxt;
    logic                 w_we;
    logic [SET_LEN-1:0]   w_waddr;
    logic [BITS-1:0]      w_wdata;

    // Index formation: the update side always uses the history snapshot the
    // branch was predicted with, so training lands on the entry that was read.
    generate
        if (MODE == 0) begin : g_bimodal
            assign w_qi = bus.PC_query[PC_LSB +: SET_LEN];
            assign w_ui = bus.PC_update[PC_LSB +: SET_LEN];
        end else begin : g_gshare
            assign w_qi = bus.PC_query[PC_LSB +: SET_LEN]  ^ SET_LEN'(ghr_q);
            assign w_ui = bus.PC_update[PC_LSB +: SET_LEN] ^ SET_LEN'(bus.GHR_update);
        end
    endgenerate

    generate
        if (GHR_LEN == 1) begin : g_ghr_one
            assign ghr_d = bus.BR;
        end else begin : g_ghr_shift
            assign ghr_d = {ghr_q[GHR_LEN-2:0], bus.BR};
        end
    endgenerate

    assign w_upd_cur = table_q[w_ui];

    always_comb begin
        w_upd_nxt = w_upd_cur;
        if (bus.BR) begin
            if (w_upd_cur != c_max_val) begin
                w_upd_nxt = w_upd_cur + 1'b1;
            end
        end else begin
            if (w_upd_cur != '0) begin
                w_upd_nxt = w_upd_cur - 1'b1;
            end
        end
    end

    // Single write port shared by the init sweep and training; reset blocks both.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_ui;
        w_wdata = w_upd_nxt;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                w_we    = 1'b1;
                w_waddr = idx_q;
                w_wdata = c_init_val;
            end else if (bus.update) begin
                w_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            table_q[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ghr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == {SET_LEN{1'b1}}) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.update) begin
                        ghr_q <= ghr_d;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BHT_br  = (state_q == ST_RUN) && (table_q[w_qi] > c_threshold);
    assign bus.GHR_out = ghr_q;
    assign bus.ready   = ready_q;

    logic w_unused;
    assign w_unused = &{1'b0, bus.PC_query, bus.PC_update, bus.GHR_update};

endmodule
`default_nettype wire
